// File: rtl/weight_stream_buffer.sv
// Dual-port weight buffer: port A random read/byte-write, port B autonomous burst streamer.
// Optional collision counter output col_cnt is enabled by defining WSB_COLLISION_CNT_EN.
module weight_stream_buffer #(
  parameter int DATA_W = 128,
  parameter int LANES  = 8,
  parameter int DEPTH  = 2048,
  parameter int LEN_W  = 12,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int LANE_W = DATA_W / LANES
) (
  input  logic              CK,
  input  logic              rstn,
  input  logic              a_req,
  input  logic [LANES-1:0]  a_wen,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  output logic [DATA_W-1:0] a_dout,
  output logic              a_dvalid,
  input  logic              b_start,
  input  logic              b_abort,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [LEN_W-1:0]  b_len,
  output logic              b_busy,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              b_done
`ifdef WSB_COLLISION_CNT_EN
  ,
  output logic [15:0]       col_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_q_reg;
  logic              a_has_reg;
  logic              a_dvalid_reg;
  logic [DATA_W-1:0] b_q_reg;
  logic [LANES-1:0]  col_mask_reg;
  logic [DATA_W-1:0] col_din_reg;
  logic [DATA_W-1:0] b_word;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        occ_reg, occ_next;
  logic              pend_reg;

  logic [ADDR_W-1:0] addr_reg, addr_next, addr_wrap;
  logic [LEN_W-1:0]  rem_reg, rem_next;
  logic              done_reg, done_next;
  logic              issue, start_acc, pop, room;
  logic [2:0]        load;
  logic              a_rd;

  assign a_rd = a_req & (&a_wen);

  // Memory arrays: no reset, registered reads (read-first; write-first fixed up below)
  always_ff @(posedge CK) begin
    for (int i = 0; i < LANES; i++) begin
      if (a_req && !a_wen[i])
        mem[a_addr][i*LANE_W +: LANE_W] <= a_din[i*LANE_W +: LANE_W];
    end
    if (a_rd)
      a_q_reg <= mem[a_addr];
    if (issue)
      b_q_reg <= mem[addr_reg];
    col_mask_reg <= (issue && a_req && (a_addr == addr_reg)) ? ~a_wen : '0;
    col_din_reg  <= a_din;
    if (pend_reg)
      fifo_mem[wr_ptr_reg] <= b_word;
  end

  // Per-lane bypass of same-cycle A write onto the B read word
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_merge
      assign b_word[gi*LANE_W +: LANE_W] = col_mask_reg[gi] ? col_din_reg[gi*LANE_W +: LANE_W]
                                                             : b_q_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      a_dvalid_reg <= 1'b0;
      a_has_reg    <= 1'b0;
    end else begin
      a_dvalid_reg <= a_rd;
      a_has_reg    <= a_has_reg | a_rd;
    end
  end

  assign a_dvalid = a_dvalid_reg;
  assign a_dout   = a_has_reg ? a_q_reg : '0;

  assign b_valid  = (occ_reg != 2'd0);
  assign b_data   = b_valid ? fifo_mem[rd_ptr_reg] : '0;
  assign pop      = b_valid & b_ready;
  assign load     = {1'b0, occ_reg} + {2'b00, pend_reg};
  assign room     = (load - {2'b00, pop}) < 3'd2;
  assign occ_next = occ_reg + {1'b0, pend_reg} - {1'b0, pop};
  assign addr_wrap = (addr_reg == ADDR_W'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    rem_next   = rem_reg;
    issue      = 1'b0;
    start_acc  = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (b_start && !b_abort) begin
          start_acc = 1'b1;
          addr_next = b_base;
          rem_next  = b_len;
          if (b_len == '0) done_next = 1'b1;
          else             state_next = RUN;
        end
      end
      RUN: begin
        if (b_abort) begin
          state_next = IDLE;
        end else if (room) begin
          issue     = 1'b1;
          addr_next = addr_wrap;
          rem_next  = rem_reg - 1'b1;
          if (rem_reg == LEN_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (b_abort) begin
          state_next = IDLE;
        end else if (occ_next == 2'd0 && !pend_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      rem_reg    <= '0;
      done_reg   <= 1'b0;
      occ_reg    <= 2'd0;
      pend_reg   <= 1'b0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
      if (b_abort) begin
        occ_reg    <= 2'd0;
        pend_reg   <= 1'b0;
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        occ_reg  <= occ_next;
        pend_reg <= issue;
        if (pend_reg) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)      rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

  assign b_busy = (state_reg != IDLE);
  assign b_done = done_reg;

`ifdef WSB_COLLISION_CNT_EN
  logic [15:0] col_cnt_reg;
  logic        collision;

  assign collision = issue & a_req & ~(&a_wen) & (a_addr == addr_reg);

  always_ff @(posedge CK or negedge rstn) begin
    if (!rstn)
      col_cnt_reg <= '0;
    else if (start_acc)
      col_cnt_reg <= '0;
    else if (collision && col_cnt_reg != 16'hFFFF)
      col_cnt_reg <= col_cnt_reg + 1'b1;
  end

  assign col_cnt = col_cnt_reg;
`endif

endmodule

// File: tb/tb_weight_stream_buffer.sv
// Directed bench for weight_stream_buffer with a scoreboard queue on the stream port.
module tb_weight_stream_buffer;

  logic         CK = 1'b0;
  logic         rstn;
  logic         a_req;
  logic [7:0]   a_wen;
  logic [10:0]  a_addr;
  logic [127:0] a_din;
  logic [127:0] a_dout;
  logic         a_dvalid;
  logic         b_start, b_abort, b_busy, b_valid, b_ready, b_done;
  logic [10:0]  b_base;
  logic [11:0]  b_len;
  logic [127:0] b_data;
`ifdef WSB_COLLISION_CNT_EN
  logic [15:0]  col_cnt;
`endif

  weight_stream_buffer dut (
    .CK(CK), .rstn(rstn),
    .a_req(a_req), .a_wen(a_wen), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout), .a_dvalid(a_dvalid),
    .b_start(b_start), .b_abort(b_abort), .b_base(b_base), .b_len(b_len),
    .b_busy(b_busy), .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .b_done(b_done)
`ifdef WSB_COLLISION_CNT_EN
    , .col_cnt(col_cnt)
`endif
  );

  always #5 CK = ~CK;

  int pass_cnt = 0;
  int total_cnt = 0;
  int nbeats = 0;
  logic [127:0] exp_q[$];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic a_write(input logic [10:0] addr, input logic [7:0] wen, input logic [127:0] d);
    a_req = 1'b1; a_wen = wen; a_addr = addr; a_din = d;
    tick();
    a_req = 1'b0; a_wen = 8'hFF;
    $display("A write addr=%0d wen=%h data=%h", addr, wen, d);
  endtask

  task automatic a_read(input logic [10:0] addr, input logic [127:0] exp, input string tag);
    a_req = 1'b1; a_wen = 8'hFF; a_addr = addr;
    tick();
    a_req = 1'b0;
    $display("A read addr=%0d dout=%h", addr, a_dout);
    check({tag, "_dv"}, {127'd0, a_dvalid}, 128'd1);
    check(tag, a_dout, exp);
  endtask

  task automatic start_burst(input logic [10:0] base, input logic [11:0] len);
    b_base = base; b_len = len; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    $display("B start base=%0d len=%0d", base, len);
  endtask

  // Stream monitor: compares each transferred beat with the scoreboard head
  always @(negedge CK) begin
    logic [127:0] e;
    if (rstn && prev_stall && b_valid)
      check("stall_hold", b_data, prev_data);
    if (rstn && b_valid && b_ready) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = ~b_data;
      $display("B beat data=%h", b_data);
      check("stream", b_data, e);
      nbeats++;
    end
    prev_stall = rstn && b_valid && !b_ready;
    prev_data  = b_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got_done;
    logic [3:0] pat;
    logic [127:0] col_word;

    rstn = 1'b0; a_req = 1'b0; a_wen = 8'hFF; a_addr = '0; a_din = '0;
    b_start = 1'b0; b_abort = 1'b0; b_base = '0; b_len = '0; b_ready = 1'b0;
    tick(); tick();
    check("rst_a_dout",   a_dout, 128'd0);
    check("rst_a_dvalid", {127'd0, a_dvalid}, 128'd0);
    check("rst_b_busy",   {127'd0, b_busy}, 128'd0);
    check("rst_b_valid",  {127'd0, b_valid}, 128'd0);
    check("rst_b_data",   b_data, 128'd0);
    check("rst_b_done",   {127'd0, b_done}, 128'd0);
    rstn = 1'b1;
    tick();

    // 1: byte write / read on port A
    a_write(11'd5, 8'h00, {128{1'b1}});
    a_read(11'd5, {128{1'b1}}, "t1_ones");
    a_write(11'd5, 8'h00, 128'd0);
    check("t1_wr_nodv", {127'd0, a_dvalid}, 128'd0);
    check("t1_hold", a_dout, {128{1'b1}});
    a_read(11'd5, 128'd0, "t1_zero");
    tick();
    check("t1_dv_pulse", {127'd0, a_dvalid}, 128'd0);
    check("t1_dout_hold", a_dout, 128'd0);

    // memory image for bursts
    a_write(11'd2045, 8'h00, 128'd2045);
    a_write(11'd2046, 8'h00, 128'd2046);
    a_write(11'd2047, 8'h00, 128'd2047);
    a_write(11'd0, 8'h00, 128'd0);
    a_write(11'd1, 8'h00, 128'd1);
    a_write(11'd2, 8'h00, 128'd2);
    a_write(11'd10, 8'h00, 128'h1111_2222_3333_4444_5555_6666_7777_000A);

    // 2: wrapping burst at full rate
    b_ready = 1'b1;
    exp_q.push_back(128'd2045); exp_q.push_back(128'd2046); exp_q.push_back(128'd2047);
    exp_q.push_back(128'd0);    exp_q.push_back(128'd1);    exp_q.push_back(128'd2);
    start_burst(11'd2045, 12'd6);
    check("t2_busy", {127'd0, b_busy}, 128'd1);
    for (int i = 0; i < 10 && !b_valid; i++) tick();
    for (int i = 0; i < 6; i++) begin
      check("t2_valid", {127'd0, b_valid}, 128'd1);
      tick();
    end
    check("t2_done", {127'd0, b_done}, 128'd1);
    check("t2_valid_end", {127'd0, b_valid}, 128'd0);
    check("t2_idle", {127'd0, b_busy}, 128'd0);
    tick();
    check("t2_done_pulse", {127'd0, b_done}, 128'd0);

    // 3: same burst with back-pressure
    exp_q.push_back(128'd2045); exp_q.push_back(128'd2046); exp_q.push_back(128'd2047);
    exp_q.push_back(128'd0);    exp_q.push_back(128'd1);    exp_q.push_back(128'd2);
    nbeats = 0;
    got_done = 0;
    pat = 4'b1001;
    start_burst(11'd2045, 12'd6);
    for (int c = 0; c < 80 && got_done == 0; c++) begin
      b_ready = pat[c % 4];
      tick();
      if (b_done) got_done++;
    end
    b_ready = 1'b1;
    check("t3_done", 128'(got_done), 128'd1);
    check("t3_beats", 128'(nbeats), 128'd6);
    check("t3_sb_empty", 128'(exp_q.size()), 128'd0);

    // 4: same-cycle collision, write-first per lane
    col_word = 128'h1111_2222_3333_4444_5555_6666_7777_BEEF;
    exp_q.push_back(col_word);
    start_burst(11'd10, 12'd1);
    a_req = 1'b1; a_wen = 8'hFE; a_addr = 11'd10;
    a_din = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_BEEF;
    tick();
    a_req = 1'b0; a_wen = 8'hFF;
    got_done = 0;
    for (int c = 0; c < 20 && got_done == 0; c++) begin
      if (b_done) got_done++;
      else tick();
    end
    check("t4_done", 128'(got_done), 128'd1);
    check("t4_sb_empty", 128'(exp_q.size()), 128'd0);
`ifdef WSB_COLLISION_CNT_EN
    check("t4_col_cnt", {112'd0, col_cnt}, 128'd1);
`endif
    a_read(11'd10, col_word, "t4_mem");

    // 5: abort mid-burst, abort-beats-start, zero-length start
    b_ready = 1'b0;
    start_burst(11'd2045, 12'd6);
    tick(); tick(); tick();
    check("t5_valid_pre", {127'd0, b_valid}, 128'd1);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    check("t5_valid", {127'd0, b_valid}, 128'd0);
    check("t5_idle", {127'd0, b_busy}, 128'd0);
    check("t5_nodone", {127'd0, b_done}, 128'd0);
    tick();
    check("t5_drop", {127'd0, b_valid}, 128'd0);
    b_abort = 1'b1;
    start_burst(11'd0, 12'd3);
    b_abort = 1'b0;
    check("t5_abort_wins", {127'd0, b_busy}, 128'd0);
    tick();
    check("t5_abort_nodone", {127'd0, b_done}, 128'd0);
    b_ready = 1'b1;
    start_burst(11'd0, 12'd0);
    check("t5_len0_done", {127'd0, b_done}, 128'd1);
    check("t5_len0_idle", {127'd0, b_busy}, 128'd0);
    tick();
    check("t5_len0_pulse", {127'd0, b_done}, 128'd0);
    check("t5_len0_nodata", {127'd0, b_valid}, 128'd0);

    // 6: reset during RUN
    b_ready = 1'b0;
    start_burst(11'd2045, 12'd6);
    tick(); tick(); tick();
    check("t6_running", {127'd0, b_valid & b_busy}, 128'd1);
    rstn = 1'b0;
    #1;
    check("t6_b_valid", {127'd0, b_valid}, 128'd0);
    check("t6_b_busy",  {127'd0, b_busy}, 128'd0);
    check("t6_b_data",  b_data, 128'd0);
    check("t6_a_dout",  a_dout, 128'd0);
`ifdef WSB_COLLISION_CNT_EN
    check("t6_col_cnt", {112'd0, col_cnt}, 128'd0);
`endif
    #1;
    rstn = 1'b1;
    tick();
    a_read(11'd2047, 128'd2047, "t6_mem_kept");
    check("t6_sb_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
